// File: rtl/alu_pkg.sv
// Shared ALU control codes and FSM encodings for the decoder and the iterative ALU.
package alu_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_MUL = 3'b100;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/alu_iterative_if.sv
// Issue/result bundle between the execute stage issuer and alu_iterative.
interface alu_iterative_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start_i;
  logic [2:0]       ALUCtrl_i;
  logic [WIDTH-1:0] data1_i;
  logic [WIDTH-1:0] data2_i;
  logic [WIDTH-1:0] data_o;
  logic             Zero_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, ALUCtrl_i, data1_i, data2_i,
    input  data_o, Zero_o, busy_o, done_o
  );

  modport slave (
    input  start_i, ALUCtrl_i, data1_i, data2_i,
    output data_o, Zero_o, busy_o, done_o
  );
endinterface

// File: rtl/alu_mul_step.sv
// One combinational shift-add multiply step: conditional accumulate, then shift operands.
module alu_mul_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] mcand_o,
  output logic [WIDTH-1:0] mplier_o
);

  always_comb begin
    acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    mcand_o  = mcand_i << 1;
    mplier_o = mplier_i >> 1;
  end

endmodule

// File: rtl/alu_iterative.sv
// Execute-stage ALU: add/sub/and/or in one cycle, mul as a WIDTH-step shift-add
// iteration behind a start/busy/done handshake.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input logic             clk_i,
  input logic             rst_i,
  alu_iterative_if.slave  bus
);

  localparam int unsigned   CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;

  logic [WIDTH-1:0] acc_step, mcand_step, mplier_step;
  logic [WIDTH-1:0] alu_res;

  alu_mul_step #(.WIDTH(WIDTH)) u_step (
    .acc_i    (acc_q),
    .mcand_i  (mcand_q),
    .mplier_i (mplier_q),
    .acc_o    (acc_step),
    .mcand_o  (mcand_step),
    .mplier_o (mplier_step)
  );

  // Undefined codes fall through to add, matching the decoder default.
  always_comb begin
    case (bus.ALUCtrl_i)
      ALU_AND: alu_res = bus.data1_i & bus.data2_i;
      ALU_OR:  alu_res = bus.data1_i | bus.data2_i;
      ALU_SUB: alu_res = bus.data1_i + ~bus.data2_i + WIDTH'(1);
      default: alu_res = bus.data1_i + bus.data2_i;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    data_d   = data_q;
    zero_d   = zero_q;
    case (state_q)
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          data_d  = acc_step;
          zero_d  = (acc_step == '0);
          state_d = ST_DONE;
        end
      end
      default: begin
        // IDLE and DONE both accept, so results can issue back-to-back.
        if (bus.start_i) begin
          if (bus.ALUCtrl_i == ALU_MUL) begin
            mcand_d  = bus.data1_i;
            mplier_d = bus.data2_i;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = ST_MUL;
          end else begin
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      data_q   <= data_d;
      zero_q   <= zero_d;
    end
  end

  assign bus.data_o = data_q;
  assign bus.Zero_o = zero_q;
  assign bus.busy_o = (state_q == ST_MUL);
  assign bus.done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_alu_iterative.sv
// Directed and random checks of alu_iterative against an arithmetic reference model.
module tb_alu_iterative;

  localparam int unsigned WIDTH = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int total = 0;
  int bad   = 0;

  alu_iterative_if #(.WIDTH(WIDTH)) bus ();

  alu_iterative #(.WIDTH(WIDTH)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [WIDTH-1:0] ref_res(input logic [2:0] op,
                                               input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [2*WIDTH-1:0] p;
    case (op)
      3'b000:  ref_res = a & b;
      3'b001:  ref_res = a | b;
      3'b110:  ref_res = a - b;
      3'b100:  begin p = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b}; ref_res = p[WIDTH-1:0]; end
      default: ref_res = a + b;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Issue one op, then wait (bounded) for done; lat counts edges from accept.
  task automatic run_op(input logic [2:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        output int lat, output int busy_cnt,
                        output logic [WIDTH-1:0] d, output logic z);
    bus.start_i   = 1'b1;
    bus.ALUCtrl_i = op;
    bus.data1_i   = a;
    bus.data2_i   = b;
    tick();
    bus.start_i = 1'b0;
    bus.data1_i = $urandom;
    bus.data2_i = $urandom;
    lat = 1;
    busy_cnt = 0;
    while (bus.done_o !== 1'b1 && lat < 60) begin
      if (bus.busy_o === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    d = bus.data_o;
    z = bus.Zero_o;
  endtask

  initial begin
    int lat, bcnt, dones, first_done;
    logic [WIDTH-1:0] d, a, b, e;
    logic z;
    logic [2:0] op;
    logic [2:0] ops [8];

    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b100, 3'b011, 3'b101, 3'b111};
    bus.start_i   = 1'b0;
    bus.ALUCtrl_i = '0;
    bus.data1_i   = '0;
    bus.data2_i   = '0;
    tick();
    tick();
    chk("rst_data", bus.data_o, 0);
    chk("rst_zero", bus.Zero_o, 1);
    chk("rst_busy", bus.busy_o, 0);
    chk("rst_done", bus.done_o, 0);
    rst_i = 1'b1;
    tick();

    run_op(3'b010, 5, 7, lat, bcnt, d, z);
    chk("add_lat", lat, 1);
    chk("add_data", d, 12);
    chk("add_zero", z, 0);
    chk("add_busy", bus.busy_o, 0);

    run_op(3'b110, 7, 7, lat, bcnt, d, z);
    chk("sub_lat", lat, 1);
    chk("sub_data", d, 0);
    chk("sub_zero", z, 1);
    run_op(3'b000, 32'hF0F0, 32'h0FF0, lat, bcnt, d, z);
    chk("b2b_and_lat", lat, 1);
    chk("b2b_and_data", d, 32'h00F0);
    tick();
    chk("done_one_cycle", bus.done_o, 0);
    chk("data_held", bus.data_o, 32'h00F0);

    run_op(3'b100, 3, 32'hFFFF_FFFE, lat, bcnt, d, z);
    chk("mul_lat", lat, WIDTH + 1);
    chk("mul_busy_cycles", bcnt, WIDTH);
    chk("mul_data", d, 32'hFFFF_FFFA);
    chk("mul_zero", z, 0);
    run_op(3'b100, 32'h10000, 32'h10000, lat, bcnt, d, z);
    chk("mul_wrap_data", d, 0);
    chk("mul_wrap_zero", z, 1);

    // Start during busy must be ignored.
    bus.start_i = 1'b1; bus.ALUCtrl_i = 3'b100; bus.data1_i = 6; bus.data2_i = 7;
    tick();
    bus.start_i = 1'b0;
    dones = 0; first_done = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (bus.done_o === 1'b1) begin
        dones++;
        if (first_done == 0) begin
          first_done = cyc;
          chk("busy_start_data", bus.data_o, 42);
        end
      end
      bus.start_i = (cyc == 10);
      if (cyc == 10) begin
        bus.ALUCtrl_i = 3'b010; bus.data1_i = 1; bus.data2_i = 1;
      end
      tick();
    end
    bus.start_i = 1'b0;
    chk("busy_start_lat", first_done, WIDTH + 1);
    chk("busy_start_dones", dones, 1);
    chk("busy_start_final", bus.data_o, 42);

    // Reset mid-multiply.
    bus.start_i = 1'b1; bus.ALUCtrl_i = 3'b100; bus.data1_i = 6; bus.data2_i = 7;
    tick();
    bus.start_i = 1'b0;
    for (int cyc = 2; cyc <= 15; cyc++) tick();
    chk("pre_rst_busy", bus.busy_o, 1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_data", bus.data_o, 0);
    chk("mid_rst_zero", bus.Zero_o, 1);
    chk("mid_rst_busy", bus.busy_o, 0);
    dones = 0;
    for (int cyc = 0; cyc < 3; cyc++) begin
      tick();
      if (bus.done_o !== 1'b0) dones++;
    end
    rst_i = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      tick();
      if (bus.done_o !== 1'b0) dones++;
    end
    chk("rst_no_done", dones, 0);
    run_op(3'b010, 2, 2, lat, bcnt, d, z);
    chk("post_rst_add", d, 4);

    run_op(3'b111, 9, 1, lat, bcnt, d, z);
    chk("undef_lat", lat, 1);
    chk("undef_busy", bcnt, 0);
    chk("undef_data", d, 10);

    for (int i = 0; i < 24; i++) begin
      op = ops[$urandom_range(7)];
      a = $urandom;
      b = (i % 4 == 0) ? a : $urandom;
      if (i % 6 == 0) b = '0;
      e = ref_res(op, a, b);
      run_op(op, a, b, lat, bcnt, d, z);
      chk($sformatf("rnd%0d_op%0b_data", i, op), d, e);
      chk($sformatf("rnd%0d_zero", i), z, (e == '0));
      chk($sformatf("rnd%0d_lat", i), lat, (op == 3'b100) ? WIDTH + 1 : 1);
      if ($urandom_range(1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
